// File: rtl/hdlc_mon_pkg.sv
//==============================================================================
// Module   : hdlc_mon_pkg
// Purpose  : Shared constants, error-rule indices and the saturating counter
//            helper for the HDLC Rx protocol monitor.
// Contents : HDLC_FLAG  - the 8-bit HDLC flag pattern (01111110)
//            err_idx_t  - bit positions of each rule in the violation vector
//            sat_inc()  - saturating error-counter update with clear
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package hdlc_mon_pkg;

   localparam logic [7:0] HDLC_FLAG = 8'h7E;

   // Widest error counter the helper can service.
   localparam int SAT_MAX_W = 32;

   localparam int NUM_ERR = 4;

   typedef enum logic [1:0] {
      ERR_FLAG  = 2'd0,
      ERR_ABORT = 2'd1,
      ERR_IDLE  = 2'd2,
      ERR_OVF   = 2'd3
   } err_idx_t;

   // Counter update for one rule. A clear wins over the held value but a hit
   // in the same cycle is still recorded, so clear+hit leaves the count at 1.
   // 'width' is the real counter width; the counter sticks at all-ones.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(
      input logic [SAT_MAX_W-1:0] cnt,
      input logic                 clr,
      input logic                 hit,
      input int unsigned          width
   );
      logic [SAT_MAX_W-1:0] w_max;
      w_max = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
      if (clr) begin
         sat_inc = {{(SAT_MAX_W-1){1'b0}}, hit};
      end else if (hit && (cnt != w_max)) begin
         sat_inc = cnt + SAT_MAX_W'(1);
      end else begin
         sat_inc = cnt;
      end
   endfunction

endpackage : hdlc_mon_pkg

`default_nettype wire

// File: rtl/hdlc_mon_latchk.sv
//==============================================================================
// Module   : hdlc_mon_latchk
// Purpose  : Generic "trigger now, expect a strobe exactly LAT cycles later"
//            checker. Every trigger is tracked independently, so overlapping
//            obligations each get their own deadline.
// Ports    : Clk      - clock
//            Rst      - synchronous active-high reset (drops pending work)
//            trig     - starts an obligation this cycle
//            expected - strobe that must be high at the deadline cycle
//            viol     - high in a deadline cycle whose strobe is missing
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hdlc_mon_latchk #(
   parameter int LAT = 2
) (
   input  logic Clk,
   input  logic Rst,
   input  logic trig,
   input  logic expected,
   output logic viol
);

   // Bit k set means an obligation triggered k+1 cycles ago.
   logic [LAT-1:0] r_pend;

   generate
      if (LAT == 1) begin : g_lat1
         always_ff @(posedge Clk) begin
            if (Rst) begin
               r_pend <= '0;
            end else begin
               r_pend <= trig;
            end
         end
      end else begin : g_latn
         always_ff @(posedge Clk) begin
            if (Rst) begin
               r_pend <= '0;
            end else begin
               r_pend <= {r_pend[LAT-2:0], trig};
            end
         end
      end
   endgenerate

   assign viol = r_pend[LAT-1] & ~expected;

endmodule : hdlc_mon_latchk

`default_nettype wire

// File: rtl/hdlc_rx_protocol_monitor.sv
//==============================================================================
// Module   : hdlc_rx_protocol_monitor
// Purpose  : Passive runtime checker for the HDLC Rx path. Watches the serial
//            line, the enables and the Rx status strobes and counts
//            flag-latency, abort-latency and idle-pattern violations in
//            saturating counters with a sticky summary flag.
// Ports    : Clk, Rst          - clock, synchronous active-high reset
//            Rx                - serial receive line
//            TxEN, RxEN        - transmitter / receiver enables
//            Rx_FlagDetect     - flag-detect strobe under observation
//            Rx_AbortDetect    - abort-detect strobe under observation
//            Rx_ValidFrame     - frame-in-progress under observation
//            Rx_AbortSignal    - abort indication under observation
//            Clr               - clears counters and ErrAny
//            ErrFlagCnt        - flag-latency violations
//            ErrAbortCnt       - abort-latency violations
//            ErrIdleCnt        - idle-pattern violations
//            ErrAny            - sticky: any violation since reset/Clr
//            IdlePass          - pulse per IDLE_LEN ones with both enables low
// Option   : HDLC_MON_OVERFLOW_CHK_EN adds Rx_Overflow (in) and ErrOvfCnt
//            (out); overflow outside a valid frame is then a violation.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hdlc_rx_protocol_monitor
   import hdlc_mon_pkg::*;
#(
   parameter int FLAG_LAT  = 2,
   parameter int ABORT_LAT = 1,
   parameter int IDLE_LEN  = 8,
   parameter int CNT_W     = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Rx,
   input  logic             TxEN,
   input  logic             RxEN,
   input  logic             Rx_FlagDetect,
   input  logic             Rx_AbortDetect,
   input  logic             Rx_ValidFrame,
   input  logic             Rx_AbortSignal,
   input  logic             Clr,
`ifdef HDLC_MON_OVERFLOW_CHK_EN
   input  logic             Rx_Overflow,
   output logic [CNT_W-1:0] ErrOvfCnt,
`endif
   output logic [CNT_W-1:0] ErrFlagCnt,
   output logic [CNT_W-1:0] ErrAbortCnt,
   output logic [CNT_W-1:0] ErrIdleCnt,
   output logic             ErrAny,
   output logic             IdlePass
);

   localparam int REM_W = $clog2(IDLE_LEN);

   logic [7:0]         r_hist;
   logic               w_flagMatch;
   logic               w_abortTrig;
   logic               w_bothLow;
   logic [REM_W-1:0]   r_rem;
   logic [REM_W-1:0]   r_run;
   logic               r_idlePass;
   logic [NUM_ERR-1:0] w_viol;
   logic               w_anyViol;
   logic [CNT_W-1:0]   r_errFlagCnt;
   logic [CNT_W-1:0]   r_errAbortCnt;
   logic [CNT_W-1:0]   r_errIdleCnt;
   logic               r_errAny;

   //---------------------------------------------------------------------------
   // Flag rule. History resets to all-ones so no 0...0 pattern can be formed
   // until eight fresh bits have arrived.
   //---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_hist <= 8'hFF;
      end else begin
         r_hist <= {r_hist[6:0], Rx};
      end
   end

   assign w_flagMatch = ({r_hist[6:0], Rx} == HDLC_FLAG);

   hdlc_mon_latchk #(.LAT(FLAG_LAT)) u_flagChk (
      .Clk      (Clk),
      .Rst      (Rst),
      .trig     (w_flagMatch),
      .expected (Rx_FlagDetect),
      .viol     (w_viol[ERR_FLAG])
   );

   //---------------------------------------------------------------------------
   // Abort rule: only an abort inside a frame obliges Rx_AbortSignal.
   //---------------------------------------------------------------------------
   assign w_abortTrig = Rx_AbortDetect & Rx_ValidFrame;

   hdlc_mon_latchk #(.LAT(ABORT_LAT)) u_abortChk (
      .Clk      (Clk),
      .Rst      (Rst),
      .trig     (w_abortTrig),
      .expected (Rx_AbortSignal),
      .viol     (w_viol[ERR_ABORT])
   );

   //---------------------------------------------------------------------------
   // Idle rule. r_rem keeps the line obligated for IDLE_LEN-1 cycles after the
   // last both-enables-low cycle, so IDLE_LEN ones must follow each such cycle.
   //---------------------------------------------------------------------------
   assign w_bothLow        = ~TxEN & ~RxEN;
   assign w_viol[ERR_IDLE] = (w_bothLow | (r_rem != '0)) & ~Rx;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_rem      <= '0;
         r_run      <= '0;
         r_idlePass <= 1'b0;
      end else begin
         if (w_bothLow) begin
            r_rem <= REM_W'(IDLE_LEN - 1);
         end else if (r_rem != '0) begin
            r_rem <= r_rem - REM_W'(1);
         end

         // Run wraps at IDLE_LEN-1 -> 0 on the IDLE_LEN-th one, so it never
         // needs to hold IDLE_LEN itself.
         if (w_bothLow && Rx) begin
            if (r_run == REM_W'(IDLE_LEN - 1)) begin
               r_run      <= '0;
               r_idlePass <= 1'b1;
            end else begin
               r_run      <= r_run + REM_W'(1);
               r_idlePass <= 1'b0;
            end
         end else begin
            r_run      <= '0;
            r_idlePass <= 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Optional overflow rule.
   //---------------------------------------------------------------------------
`ifdef HDLC_MON_OVERFLOW_CHK_EN
   logic [CNT_W-1:0] r_errOvfCnt;

   assign w_viol[ERR_OVF] = Rx_Overflow & ~Rx_ValidFrame;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_errOvfCnt <= '0;
      end else begin
         r_errOvfCnt <= CNT_W'(sat_inc(SAT_MAX_W'(r_errOvfCnt), Clr,
                                       w_viol[ERR_OVF], CNT_W));
      end
   end

   assign ErrOvfCnt = r_errOvfCnt;
`else
   assign w_viol[ERR_OVF] = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Counters and sticky summary.
   //---------------------------------------------------------------------------
   assign w_anyViol = |w_viol;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_errFlagCnt  <= '0;
         r_errAbortCnt <= '0;
         r_errIdleCnt  <= '0;
         r_errAny      <= 1'b0;
      end else begin
         r_errFlagCnt  <= CNT_W'(sat_inc(SAT_MAX_W'(r_errFlagCnt), Clr,
                                         w_viol[ERR_FLAG], CNT_W));
         r_errAbortCnt <= CNT_W'(sat_inc(SAT_MAX_W'(r_errAbortCnt), Clr,
                                         w_viol[ERR_ABORT], CNT_W));
         r_errIdleCnt  <= CNT_W'(sat_inc(SAT_MAX_W'(r_errIdleCnt), Clr,
                                         w_viol[ERR_IDLE], CNT_W));
         r_errAny      <= Clr ? w_anyViol : (r_errAny | w_anyViol);
      end
   end

   assign ErrFlagCnt  = r_errFlagCnt;
   assign ErrAbortCnt = r_errAbortCnt;
   assign ErrIdleCnt  = r_errIdleCnt;
   assign ErrAny      = r_errAny;
   assign IdlePass    = r_idlePass;

endmodule : hdlc_rx_protocol_monitor

`default_nettype wire

// File: tb/tb_hdlc_rx_protocol_monitor.sv
//==============================================================================
// Module   : tb_hdlc_rx_protocol_monitor
// Purpose  : Directed self-checking bench for hdlc_rx_protocol_monitor with
//            2-bit counters so saturation is reachable quickly.
// Option   : HDLC_MON_OVERFLOW_CHK_EN also exercises the overflow rule.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hdlc_rx_protocol_monitor;

   localparam int CW = 2;

   logic          Clk;
   logic          Rst;
   logic          Rx;
   logic          TxEN;
   logic          RxEN;
   logic          Rx_FlagDetect;
   logic          Rx_AbortDetect;
   logic          Rx_ValidFrame;
   logic          Rx_AbortSignal;
   logic          Clr;
   logic [CW-1:0] ErrFlagCnt;
   logic [CW-1:0] ErrAbortCnt;
   logic [CW-1:0] ErrIdleCnt;
   logic          ErrAny;
   logic          IdlePass;
`ifdef HDLC_MON_OVERFLOW_CHK_EN
   logic          Rx_Overflow;
   logic [CW-1:0] ErrOvfCnt;
`endif

   int nChecks = 0;
   int nFails  = 0;

   hdlc_rx_protocol_monitor #(
      .FLAG_LAT  (2),
      .ABORT_LAT (1),
      .IDLE_LEN  (8),
      .CNT_W     (CW)
   ) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Rx             (Rx),
      .TxEN           (TxEN),
      .RxEN           (RxEN),
      .Rx_FlagDetect  (Rx_FlagDetect),
      .Rx_AbortDetect (Rx_AbortDetect),
      .Rx_ValidFrame  (Rx_ValidFrame),
      .Rx_AbortSignal (Rx_AbortSignal),
      .Clr            (Clr),
`ifdef HDLC_MON_OVERFLOW_CHK_EN
      .Rx_Overflow    (Rx_Overflow),
      .ErrOvfCnt      (ErrOvfCnt),
`endif
      .ErrFlagCnt     (ErrFlagCnt),
      .ErrAbortCnt    (ErrAbortCnt),
      .ErrIdleCnt     (ErrIdleCnt),
      .ErrAny         (ErrAny),
      .IdlePass       (IdlePass)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkVal(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs set after this apply to the next cycle.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Drive the eight flag bits, MSB first: 0,1,1,1,1,1,1,0.
   task automatic sendFlagBits();
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) begin
         Rx = f[7-i];
         step();
      end
      Rx = 1'b1;
   endtask

   // Flag, then optionally the detect strobe at lastbit+2, optionally Clr
   // in that same deadline cycle.
   task automatic sendFlag(input logic det, input logic clrAtDeadline);
      sendFlagBits();
      step();
      Rx_FlagDetect = det;
      Clr           = clrAtDeadline;
      step();
      Rx_FlagDetect = 1'b0;
      Clr           = 1'b0;
   endtask

   task automatic pulseClr();
      Clr = 1'b1;
      step();
      Clr = 1'b0;
   endtask

   initial begin
      int passes;
      int firstPassAt;
      logic [14:0] b2b;

      Rst = 1'b1; Rx = 1'b1; TxEN = 1'b1; RxEN = 1'b1;
      Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0;
      Rx_AbortSignal = 1'b0; Clr = 1'b0;
`ifdef HDLC_MON_OVERFLOW_CHK_EN
      Rx_Overflow = 1'b0;
`endif
      step();
      step();
      Rst = 1'b0;

      // Reset state
      checkVal("rstFlagCnt",  ErrFlagCnt,  0);
      checkVal("rstAbortCnt", ErrAbortCnt, 0);
      checkVal("rstIdleCnt",  ErrIdleCnt,  0);
      checkVal("rstErrAny",   ErrAny,      0);
      checkVal("rstIdlePass", IdlePass,    0);

      // Flag answered on time
      sendFlag(1'b1, 1'b0);
      checkVal("flagOkCnt", ErrFlagCnt, 0);
      checkVal("flagOkAny", ErrAny,     0);

      // Flag withheld: counted on the edge after lastbit+2, not before
      sendFlagBits();
      step();
      checkVal("flagMissEarly", ErrFlagCnt, 0);
      step();
      checkVal("flagMissCnt", ErrFlagCnt, 1);
      checkVal("flagMissAny", ErrAny,     1);

      pulseClr();
      checkVal("clrFlagCnt", ErrFlagCnt, 0);
      checkVal("clrErrAny",  ErrAny,     0);

      // Abort inside a frame, signal missing next cycle
      Rx_AbortDetect = 1'b1; Rx_ValidFrame = 1'b1;
      step();
      Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx_AbortSignal = 1'b0;
      step();
      checkVal("abortMiss", ErrAbortCnt, 1);
      // Abort answered on time
      Rx_AbortDetect = 1'b1; Rx_ValidFrame = 1'b1;
      step();
      Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx_AbortSignal = 1'b1;
      step();
      Rx_AbortSignal = 1'b0;
      checkVal("abortOk", ErrAbortCnt, 1);
      // Abort outside a frame carries no obligation
      Rx_AbortDetect = 1'b1;
      step();
      Rx_AbortDetect = 1'b0;
      step();
      step();
      checkVal("abortNoFrame", ErrAbortCnt, 1);

      // Idle: 16 ones with both enables low -> two passes
      pulseClr();
      TxEN = 1'b0; RxEN = 1'b0; Rx = 1'b1;
      passes = 0;
      firstPassAt = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (IdlePass) begin
            passes++;
            if (firstPassAt == 0) firstPassAt = i;
         end
      end
      checkVal("idlePasses",    passes,      2);
      checkVal("idleFirstPass", firstPassAt, 8);
      checkVal("idleCleanCnt",  ErrIdleCnt,  0);
      // Receiver enabled: window still open three cycles later
      RxEN = 1'b1;
      step(); step(); step();
      Rx = 1'b0;
      step();
      Rx = 1'b1;
      checkVal("idleWindowViol", ErrIdleCnt, 1);
      // Window closes after IDLE_LEN cycles; zero is then legal
      step(); step(); step();
      Rx = 1'b0;
      step();
      Rx = 1'b1;
      checkVal("idleWindowShut", ErrIdleCnt, 1);
      // Zero while both enables low
      TxEN = 1'b0; RxEN = 1'b0; Rx = 1'b0;
      step();
      TxEN = 1'b1; RxEN = 1'b1; Rx = 1'b1;
      checkVal("idleLowViol", ErrIdleCnt, 2);
      for (int i = 0; i < 8; i++) step();

      // Back-to-back flags sharing a zero; only the first is answered
      pulseClr();
      b2b = 15'b011111101111110;
      for (int i = 0; i < 15; i++) begin
         Rx = b2b[14-i];
         Rx_FlagDetect = (i == 9);
         step();
      end
      Rx = 1'b1; Rx_FlagDetect = 1'b0;
      step();
      step();
      checkVal("flagShared", ErrFlagCnt, 1);

      // Saturation at 2'b11, then Clr together with a new violation
      pulseClr();
      for (int i = 0; i < 5; i++) sendFlag(1'b0, 1'b0);
      checkVal("flagSat", ErrFlagCnt, 3);
      sendFlag(1'b0, 1'b1);
      checkVal("flagClrHit",    ErrFlagCnt, 1);
      checkVal("flagClrHitAny", ErrAny,     1);

      // Reset with an obligation pending; then 1111110 must not match
      pulseClr();
      sendFlagBits();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         Rx = 1'b1;
         step();
      end
      Rx = 1'b0;
      step();
      Rx = 1'b1;
      step(); step(); step();
      checkVal("rstPendCnt", ErrFlagCnt, 0);
      checkVal("rstPendAny", ErrAny,     0);

`ifdef HDLC_MON_OVERFLOW_CHK_EN
      Rx_Overflow = 1'b1; Rx_ValidFrame = 1'b1;
      step();
      Rx_ValidFrame = 1'b0;
      step();
      Rx_Overflow = 1'b0;
      checkVal("ovfCnt", ErrOvfCnt, 1);
      checkVal("ovfAny", ErrAny,    1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule : tb_hdlc_rx_protocol_monitor

`default_nettype wire

// File: doc/hdlc_rx_protocol_monitor.md
Name: hdlc_rx_protocol_monitor

Overview:
- Synthesizable, parametrised runtime checker for the HDLC Rx path.
- Observes the serial Rx line, the enables and the Rx status outputs. Checks three rules:
  - flag-detect latency
  - abort-signal latency
  - idle-line pattern
- Keeps per-rule saturating error counters and a sticky summary flag. Readable by software or by the bench.
- Sits beside the Rx block inside the HDLC top level. Purely passive: it never drives Rx-path signals.

Parameters:
- FLAG_LAT, 2, cycles from the last bit of a received flag to the required Rx_FlagDetect (1..8).
- ABORT_LAT, 1, cycles from (Rx_AbortDetect && Rx_ValidFrame) to the required Rx_AbortSignal (1..8).
- IDLE_LEN, 8, ones required on Rx from each cycle where TxEN and RxEN are both low (2..16).
- CNT_W, 8, width of each error counter.

Ports:
- Clk  in  1  clock; every port is sampled and updated on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- Rx  in  1  serial receive line.
- TxEN  in  1  transmitter enable.
- RxEN  in  1  receiver enable.
- Rx_FlagDetect  in  1  DUT flag-detect strobe.
- Rx_AbortDetect  in  1  DUT abort-detect strobe.
- Rx_ValidFrame  in  1  DUT frame-in-progress.
- Rx_AbortSignal  in  1  DUT abort indication.
- Clr  in  1  synchronous clear of counters and sticky flag.
- ErrFlagCnt  out  CNT_W  flag-latency violations.
- ErrAbortCnt  out  CNT_W  abort-latency violations.
- ErrIdleCnt  out  CNT_W  idle-pattern violations.
- ErrAny  out  1  sticky: any violation since reset or Clr.
- IdlePass  out  1  one-cycle pulse when IDLE_LEN consecutive ones are seen while both enables are low.

Behaviour:
- Reset:
  - All counters, ErrAny, IdlePass and the pending pipelines go to 0.
  - The 8-bit Rx history register goes to 8'hFF, so no spurious flag match is possible after reset.
- Flag check:
  - hist shifts Rx in at the LSB every cycle. A match occurs when {hist[6:0],Rx} == 8'h7E, i.e. bits 0,1,1,1,1,1,1,0 in arrival order.
  - A match pushes a 1 into a FLAG_LAT-deep pending shift register.
  - When the tap is 1 and Rx_FlagDetect is 0 in that cycle, it is one violation.
  - Back-to-back flags sharing a zero produce two independent obligations.
- Abort check:
  - Trigger is Rx_AbortDetect && Rx_ValidFrame. It pushes into an ABORT_LAT-deep pending register.
  - When the tap is 1 and Rx_AbortSignal is 0, it is one violation.
  - Rx_AbortSignal asserting without a trigger is not an error.
- Idle check (down-counter rem, width clog2(IDLE_LEN)):
  - Cycle with both enables low: rem loads IDLE_LEN-1.
  - Else if rem>0: rem decrements.
  - The cycle is "obligated" if both enables are low or rem>0. An obligated cycle with Rx==0 is one violation; at most one per cycle.
  - Run counter: increments on (both enables low && Rx==1); cleared otherwise.
  - When the run counter reaches IDLE_LEN, IdlePass pulses and the counter restarts at 0.
- Counters:
  - Saturate at all-ones. They never wrap.
  - Clr has priority, but a violation in the same cycle is still counted, so the counter becomes 1.
  - ErrAny follows the same rule: Clr plus a violation leaves ErrAny at 1.
- Output timing: violations are registered. Counters and ErrAny update on the edge after the offending cycle.
- Reset mid-operation: pending obligations are discarded and are not counted.

Optional Feature:
- Macro HDLC_MON_OVERFLOW_CHK_EN.
- When defined:
  - Adds input Rx_Overflow (1) and output ErrOvfCnt (CNT_W).
  - Rx_Overflow high while Rx_ValidFrame is low counts as a violation.
  - The violation is OR-ed into ErrAny. Counter rules as above.
- When undefined: neither port nor the logic exists, and ErrAny covers the three base rules only.

Decomposition:
- Package hdlc_mon_pkg holds:
  - constant HDLC_FLAG = 8'h7E
  - enum err_idx_t {ERR_FLAG, ERR_ABORT, ERR_IDLE, ERR_OVF}
  - function sat_inc(cnt, clr, hit), the saturating counter update.
- Sub-module hdlc_mon_latchk (parameter LAT; ports Clk, Rst, trig, expect, viol) implements the generic "trigger then expect after LAT cycles" checker.
  - It is instantiated twice, for the flag and abort rules.

Test Plan:
- Rx bits 0,1,1,1,1,1,1,0 with the DUT pulsing Rx_FlagDetect 2 cycles after the last 0 -> ErrFlagCnt=0, ErrAny=0.
- Same flag with Rx_FlagDetect withheld -> ErrFlagCnt=1 on the edge after cycle lastbit+2, ErrAny=1.
- Rx_AbortDetect=1, Rx_ValidFrame=1, then Rx_AbortSignal=0 on the next cycle -> ErrAbortCnt=1. Repeat with Rx_ValidFrame=0 -> no increment.
- TxEN=RxEN=0 with Rx held at 1 for 16 cycles -> IdlePass pulses twice, ErrIdleCnt=0. Then RxEN=1 and Rx=0 three cycles later -> ErrIdleCnt=1, because the obligation window is still open.
- CNT_W=2 with 5 withheld flags -> ErrFlagCnt saturates at 3. Clr in the same cycle as a new violation -> ErrFlagCnt=1.
- Rst asserted with 1 flag obligation pending, then the flag-detect deadline passes -> ErrFlagCnt=0 and no stray match from the reset history value.
